// File: rtl/ls_instr_control.sv
// ls_instr_control
//   Control stage in front of the load/store datapath (register bank,
//   address adder, RAM). Accepts one RV64 LD/SD instruction over a
//   valid/ready handshake, decodes it and sequences the datapath controls.
//
//   Configuration macro: LS_PERF_CNT_EN adds ld_count/st_count counters.
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous, active-high reset
//   instr_valid  instr holds a valid instruction
//   instr_ready  block can accept an instruction (IDLE only)
//   instr        32-bit RV64 instruction word
//   busy         high in every state except IDLE
//   done         1-cycle pulse: LD/SD issued to the datapath
//   illegal      1-cycle pulse: accepted instruction is not LD/SD
//   enable       datapath enable
//   load_store   1 = load, 0 = store
//   ra           store-data register (rs2)
//   rb           base register (rs1)
//   rw           load destination register (rd)
//   dataIn       sign-extended 12-bit immediate, BITS+1 bits
//   ld_count     (LS_PERF_CNT_EN) loads issued, wraps at 16 bits
//   st_count     (LS_PERF_CNT_EN) stores issued, wraps at 16 bits
module ls_instr_control #(
  parameter int BITS = 63
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  output logic            busy,
  output logic            done,
  output logic            illegal,
  output logic            enable,
  output logic            load_store,
  output logic [4:0]      ra,
  output logic [4:0]      rb,
  output logic [4:0]      rw,
  output logic [BITS:0]   dataIn
`ifdef LS_PERF_CNT_EN
  ,
  output logic [15:0]     ld_count,
  output logic [15:0]     st_count
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_ADDR,
    S_WRITE,
    S_STORE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] ir_p0;
  logic        is_ld;
  logic        is_sd;
  logic [11:0] imm12;

  function automatic logic signed [BITS:0] sext_imm(input logic [11:0] imm);
    return {{(BITS - 11){imm[11]}}, imm};
  endfunction

  // Accept stage: latch the instruction word so upstream may move on.
  always_ff @(posedge clk) begin
    if (instr_valid && instr_ready) begin
      ir_p0 <= instr;
    end
  end

  // Decode of the latched word.
  always_comb begin
    is_ld = (ir_p0[6:0] == 7'b0000011) && (ir_p0[14:12] == 3'b011);
    is_sd = (ir_p0[6:0] == 7'b0100011) && (ir_p0[14:12] == 3'b011);
    imm12 = is_sd ? {ir_p0[31:25], ir_p0[11:7]} : ir_p0[31:20];
  end

  // Next state and state-decoded controls; enable/load_store see no inputs.
  always_comb begin
    state_nxt  = state;
    enable     = 1'b0;
    load_store = 1'b0;
    done       = 1'b0;
    illegal    = 1'b0;
    case (state)
      S_IDLE: begin
        if (instr_valid) begin
          state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_ld) begin
          state_nxt = S_ADDR;
        end else if (is_sd) begin
          state_nxt = S_STORE;
        end else begin
          illegal   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_ADDR: begin
        load_store = 1'b1;
        state_nxt  = S_WRITE;
      end
      S_WRITE: begin
        enable     = 1'b1;
        load_store = 1'b1;
        state_nxt  = S_DONE;
      end
      S_STORE: begin
        enable    = 1'b1;
        state_nxt = S_DONE;
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Ready is also held low while reset is asserted so no accept is advertised.
  assign instr_ready = (state == S_IDLE) && !reset;
  assign busy        = (state != S_IDLE);

  // Issue stage: state register and datapath operand registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      ra     <= '0;
      rb     <= '0;
      rw     <= '0;
      dataIn <= '0;
    end else begin
      state <= state_nxt;
      // Operands only change for a legal instruction; illegal ones leave them intact.
      if ((state == S_DECODE) && (is_ld || is_sd)) begin
        rb     <= ir_p0[19:15];
        ra     <= is_sd ? ir_p0[24:20] : 5'd0;
        rw     <= is_ld ? ir_p0[11:7] : 5'd0;
        dataIn <= sext_imm(imm12);
      end
    end
  end

`ifdef LS_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      ld_count <= '0;
      st_count <= '0;
    end else begin
      if (state == S_WRITE) begin
        ld_count <= ld_count + 16'd1;
      end
      if (state == S_STORE) begin
        st_count <= st_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ls_instr_control.sv
// tb_ls_instr_control
//   Self-checking bench for ls_instr_control. A behavioural model predicts,
//   per accepted instruction, the control waveform (from the latency rules)
//   and the operand fields (from the instruction encoding).
module tb_ls_instr_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        busy, done, illegal, enable, load_store;
  logic [4:0]  ra, rb, rw;
  logic [63:0] dataIn;
`ifdef LS_PERF_CNT_EN
  logic [15:0] ld_count, st_count;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  // model state
  logic [4:0]  m_ra, m_rb, m_rw;
  logic [63:0] m_din;
  int          m_ld, m_st;

  ls_instr_control #(.BITS(63)) dut (
    .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .busy(busy), .done(done), .illegal(illegal), .enable(enable),
    .load_store(load_store), .ra(ra), .rb(rb), .rw(rw), .dataIn(dataIn)
`ifdef LS_PERF_CNT_EN
    , .ld_count(ld_count), .st_count(st_count)
`endif
  );

  always #5 clk = ~clk;

  // 1 = LD, 2 = SD, 0 = anything else
  function automatic int kind_of(input logic [31:0] w);
    if (w[14:12] != 3'd3) return 0;
    if (w[6:0] == 7'h03) return 1;
    if (w[6:0] == 7'h23) return 2;
    return 0;
  endfunction

  task automatic model_decode(input logic [31:0] w);
    int          kind;
    logic [11:0] imm;
    kind = kind_of(w);
    if (kind == 0) return;
    imm  = (kind == 1) ? w[31:20] : {w[31:25], w[11:7]};
    m_rb = w[19:15];
    m_ra = (kind == 2) ? w[24:20] : 5'd0;
    m_rw = (kind == 1) ? w[11:7] : 5'd0;
    m_din = (imm >= 12'd2048) ? (64'(imm) - 64'd4096) : 64'(imm);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] w;
    logic [11:0] imm;
    int          sel;
    sel = $urandom_range(0, 2);
    imm = 12'($urandom);
    if (sel == 0) begin
      w = {imm, 5'($urandom), 3'b011, 5'($urandom), 7'h03};
    end else if (sel == 1) begin
      w = {imm[11:5], 5'($urandom), 5'($urandom), 3'b011, imm[4:0], 7'h23};
    end else begin
      w = $urandom;
      if (kind_of(w) != 0) w[12] = ~w[12];
    end
    return w;
  endfunction

  // Starts at a negedge of an IDLE cycle, ends at the negedge of the next IDLE cycle.
  task automatic run_instr(input logic [31:0] w, input bit noise);
    int         kind, len;
    logic [5:0] exp_c;
    kind = kind_of(w);
    len  = (kind == 1) ? 4 : (kind == 2) ? 3 : 1;
    instr       = w;
    instr_valid = 1'b1;
    #1;
    n_checks++;
    if ({enable, load_store, done, illegal, busy, instr_ready} !== 6'b000001)
      $display("FAIL idle_ctrl: got %b expected 000001", {enable, load_store, done, illegal, busy, instr_ready});
    else n_pass++;
    n_checks++;
    if ({ra, rb, rw, dataIn} !== {m_ra, m_rb, m_rw, m_din})
      $display("FAIL idle_fields: got %h expected %h", {ra, rb, rw, dataIn}, {m_ra, m_rb, m_rw, m_din});
    else n_pass++;
    for (int k = 1; k <= len; k++) begin
      @(negedge clk);
      instr_valid = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      instr       = $urandom;
      if (k == 2) model_decode(w);
      exp_c = {((kind == 1) && (k == 3)) || ((kind == 2) && (k == 2)),
               (kind == 1) && ((k == 2) || (k == 3)),
               ((kind == 1) && (k == 4)) || ((kind == 2) && (k == 3)),
               (kind == 0) && (k == 1),
               1'b1, 1'b0};
      #1;
      n_checks++;
      if ({enable, load_store, done, illegal, busy, instr_ready} !== exp_c)
        $display("FAIL ctrl instr=%h k=%0d: got %b expected %b", w, k,
                 {enable, load_store, done, illegal, busy, instr_ready}, exp_c);
      else n_pass++;
      if (k >= 2) begin
        n_checks++;
        if ({ra, rb, rw, dataIn} !== {m_ra, m_rb, m_rw, m_din})
          $display("FAIL fields instr=%h k=%0d: got %h expected %h", w, k,
                   {ra, rb, rw, dataIn}, {m_ra, m_rb, m_rw, m_din});
        else n_pass++;
      end
    end
    if (kind == 1) m_ld++;
    if (kind == 2) m_st++;
    @(negedge clk);
    instr_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    instr_valid = 1'b1;
    instr       = 32'h00813283;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      n_checks++;
      if ({instr_ready, enable, busy} !== 3'b000)
        $display("FAIL reset_ctrl c=%0d: got %b expected 000", c, {instr_ready, enable, busy});
      else n_pass++;
    end
    n_checks++;
    if ({ra, rb, rw, dataIn} !== 79'd0)
      $display("FAIL reset_fields: got %h expected 0", {ra, rb, rw, dataIn});
    else n_pass++;
    instr_valid = 1'b0;
    reset       = 1'b0;
    m_ra = '0; m_rb = '0; m_rw = '0; m_din = '0; m_ld = 0; m_st = 0;
    #1;
    n_checks++;
    if (instr_ready !== 1'b1)
      $display("FAIL reset_release_ready: got %b expected 1", instr_ready);
    else n_pass++;
  endtask

  task automatic test_ld_example();
    run_instr(32'h00813283, 1'b0);
    n_checks++;
    if ({rb, rw, dataIn} !== {5'd2, 5'd5, 64'h8})
      $display("FAIL ld_example: got rb=%0d rw=%0d dataIn=%h expected 2 5 8", rb, rw, dataIn);
    else n_pass++;
  endtask

  task automatic test_sd_example();
    run_instr(32'hFE613823, 1'b0);
    n_checks++;
    if ({rb, ra, dataIn} !== {5'd2, 5'd6, 64'hFFFF_FFFF_FFFF_FFF0})
      $display("FAIL sd_example: got rb=%0d ra=%0d dataIn=%h expected 2 6 fffffffffffffff0", rb, ra, dataIn);
    else n_pass++;
  endtask

  task automatic test_illegal();
    run_instr(32'h003100B3, 1'b0);
    #1;
    n_checks++;
    if (instr_ready !== 1'b1)
      $display("FAIL illegal_ready_again: got %b expected 1", instr_ready);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int en_seen;
    en_seen     = 0;
    instr       = 32'h00813283;
    instr_valid = 1'b1;
    @(negedge clk);              // DECODE
    instr_valid = 1'b0;
    @(negedge clk);              // ADDR
    #1;
    n_checks++;
    if ({load_store, busy, enable} !== 3'b110)
      $display("FAIL mid_addr: got %b expected 110", {load_store, busy, enable});
    else n_pass++;
    reset = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if ({enable, load_store, done, illegal, busy, instr_ready} !== 6'b000000)
      $display("FAIL mid_reset_ctrl: got %b expected 000000", {enable, load_store, done, illegal, busy, instr_ready});
    else n_pass++;
    n_checks++;
    if ({ra, rb, rw, dataIn} !== 79'd0)
      $display("FAIL mid_reset_fields: got %h expected 0", {ra, rb, rw, dataIn});
    else n_pass++;
    reset = 1'b0;
    m_ra = '0; m_rb = '0; m_rw = '0; m_din = '0;
`ifdef LS_PERF_CNT_EN
    m_ld = 0; m_st = 0;
`endif
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (enable || done) en_seen++;
    end
    n_checks++;
    if (en_seen !== 0)
      $display("FAIL mid_no_issue: got %0d enable/done cycles expected 0", en_seen);
    else n_pass++;
    run_instr(32'hFE613823, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) run_instr(rand_instr(), 1'b1);
  endtask

  task automatic test_back_to_back();
    int acc_q[$];
    int en_cnt;
    en_cnt      = 0;
    instr       = 32'h01C3B503;  // ld x10, 28(x7)
    instr_valid = 1'b1;
    for (int c = 0; c < 16; c++) begin
      #1;
      if (enable) en_cnt++;
      if (instr_valid && instr_ready) acc_q.push_back(c);
      @(negedge clk);
      if (acc_q.size() == 3) instr_valid = 1'b0;
    end
    model_decode(32'h01C3B503);
    m_ld += 3;
    n_checks++;
    if (acc_q.size() !== 3)
      $display("FAIL b2b_accepts: got %0d expected 3", acc_q.size());
    else n_pass++;
    n_checks++;
    if (acc_q.size() == 3 && !(acc_q[1] - acc_q[0] == 5 && acc_q[2] - acc_q[1] == 5))
      $display("FAIL b2b_spacing: got %0d,%0d expected 5,5", acc_q[1] - acc_q[0], acc_q[2] - acc_q[1]);
    else n_pass++;
    n_checks++;
    if (en_cnt !== 3)
      $display("FAIL b2b_enables: got %0d expected 3", en_cnt);
    else n_pass++;
  endtask

  task automatic test_counters();
`ifdef LS_PERF_CNT_EN
    n_checks++;
    if ({ld_count, st_count} !== {16'(m_ld), 16'(m_st)})
      $display("FAIL counters: got ld=%0d st=%0d expected ld=%0d st=%0d", ld_count, st_count, m_ld, m_st);
    else n_pass++;
`endif
  endtask

  initial begin
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    test_reset();
    @(negedge clk);
    test_ld_example();
    test_sd_example();
    test_illegal();
    test_reset_mid();
    test_random();
    test_back_to_back();
    test_counters();
    run_instr(rand_instr(), 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
